// File: rtl/sigma_delta_tx.sv
// Second-order 1-bit delta-sigma modulator with a one-entry PCM input buffer.
// Each accepted sample is held for R_eff = max(interpolation_ratio, 2) clocks
// and the loop emits one bitstream bit per clock (1 = +FS, 0 = -FS).
module sigma_delta_tx #(
  parameter int width = 16,
  parameter int guard = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             interpolation_ratio,
  input  logic signed [width-1:0] d_in,
  input  logic                    d_in_valid,
  output logic                    d_in_ready,
  output logic                    d_out,
  output logic                    d_clk,
  output logic                    underrun,
  output logic                    overload
);

  localparam int IW = width + guard;
  // Two headroom bits: u2 + u1 - 2*fb can exceed one extra bit when both
  // integrators sit at the clamp, and it must not wrap before the clamp.
  localparam int SW = IW + 2;
  localparam logic signed [SW-1:0] FS      = SW'(1 << (width - 1));
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (IW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX;

  logic [15:0]             cnt_q, cnt_d;
  // Reset frame length is the minimum (2), so the real ratio is picked up at
  // the first wrap, two clocks after reset release.
  logic [15:0]             r_eff_q, r_eff_d;
  logic signed [width-1:0] buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic signed [width-1:0] x_q, x_d;
  logic signed [IW-1:0]    u1_q, u1_d;
  logic signed [IW-1:0]    u2_q, u2_d;
  logic                    d_out_q, d_out_d;
  logic                    d_clk_q, d_clk_d;
  logic                    underrun_q, underrun_d;
  logic                    overload_q, overload_d;

  logic                    wrap;
  logic                    fire;
  logic signed [SW-1:0]    fb, x_ext, u1_ext, u2_ext, s1, s2;
  logic                    clip1, clip2;

  // Frame counter, input buffer handshake and active-sample hand-over.
  always_comb begin
    wrap       = (cnt_q == r_eff_q - 16'd1);
    fire       = d_in_valid && !buf_full_q;
    cnt_d      = wrap ? 16'd0 : cnt_q + 16'd1;
    r_eff_d    = r_eff_q;
    if (wrap) r_eff_d = (interpolation_ratio < 16'd2) ? 16'd2 : interpolation_ratio;
    buf_d      = fire ? d_in : buf_q;
    // A transfer on the wrap edge only happens when the buffer was empty,
    // so it refills the buffer and waits for the following wrap.
    buf_full_d = fire ? 1'b1 : (wrap ? 1'b0 : buf_full_q);
    x_d        = (wrap && buf_full_q) ? buf_q : x_q;
    d_clk_d    = wrap && buf_full_q;
    underrun_d = wrap && !buf_full_q;
  end

  // Two saturating integrators; the comparator looks at the clamped u2.
  always_comb begin
    fb     = d_out_q ? FS : -FS;
    x_ext  = {{(SW - width){x_q[width-1]}}, x_q};
    u1_ext = {{(SW - IW){u1_q[IW-1]}}, u1_q};
    u2_ext = {{(SW - IW){u2_q[IW-1]}}, u2_q};
    s1     = u1_ext + x_ext - fb;
    s2     = u2_ext + u1_ext - (fb <<< 1);
    clip1  = 1'b0;
    clip2  = 1'b0;
    u1_d   = s1[IW-1:0];
    u2_d   = s2[IW-1:0];
    if (s1 > SAT_MAX) begin
      u1_d  = SAT_MAX[IW-1:0];
      clip1 = 1'b1;
    end else if (s1 < SAT_MIN) begin
      u1_d  = SAT_MIN[IW-1:0];
      clip1 = 1'b1;
    end
    if (s2 > SAT_MAX) begin
      u2_d  = SAT_MAX[IW-1:0];
      clip2 = 1'b1;
    end else if (s2 < SAT_MIN) begin
      u2_d  = SAT_MIN[IW-1:0];
      clip2 = 1'b1;
    end
    d_out_d    = !u2_d[IW-1];
    overload_d = overload_q || clip1 || clip2;
  end

  // State registers; reset discards any buffered sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 16'd0;
      r_eff_q    <= 16'd2;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      x_q        <= '0;
      u1_q       <= '0;
      u2_q       <= '0;
      d_out_q    <= 1'b0;
      d_clk_q    <= 1'b0;
      underrun_q <= 1'b0;
      overload_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      r_eff_q    <= r_eff_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      x_q        <= x_d;
      u1_q       <= u1_d;
      u2_q       <= u2_d;
      d_out_q    <= d_out_d;
      d_clk_q    <= d_clk_d;
      underrun_q <= underrun_d;
      overload_q <= overload_d;
    end
  end

  assign d_in_ready = !buf_full_q;
  assign d_out      = d_out_q;
  assign d_clk      = d_clk_q;
  assign underrun   = underrun_q;
  assign overload   = overload_q;

endmodule

// File: tb/tb_sigma_delta_tx.sv
// Directed bench for sigma_delta_tx: reset values, idle bit pattern, DC
// densities, ratio change, underrun and sticky overload with async reset.
module tb_sigma_delta_tx;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        interpolation_ratio;
  logic signed [15:0] d_in;
  logic               d_in_valid;
  logic               d_in_ready;
  logic               d_out;
  logic               d_clk;
  logic               underrun;
  logic               overload;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_tx, n_dclk, n_ur, n_ones, n_rrise;
  int last_dclk, dclk_gap;
  logic prev_ready;
  bit seq_mode = 1'b0;

  sigma_delta_tx #(.width(16), .guard(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .interpolation_ratio (interpolation_ratio),
    .d_in                (d_in),
    .d_in_valid          (d_in_valid),
    .d_in_ready          (d_in_ready),
    .d_out               (d_out),
    .d_clk               (d_clk),
    .underrun            (underrun),
    .overload            (overload)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      if (lo == hi) $display("FAIL %s: got %0d, want %0d", tag, act, lo);
      else          $display("FAIL %s: got %0d, want %0d..%0d", tag, act, lo, hi);
    end
  endtask

  task automatic clr_cnt();
    n_tx = 0; n_dclk = 0; n_ur = 0; n_ones = 0; n_rrise = 0;
    prev_ready = d_in_ready;
  endtask

  // One clock: note whether a transfer will happen, step, then sample at +1.
  task automatic tick();
    bit fire;
    fire = d_in_valid && d_in_ready;
    @(posedge clk); #1;
    cyc++;
    if (fire) begin
      n_tx++;
      if (seq_mode) d_in = d_in + 16'sd1;
    end
    if (d_clk) begin
      n_dclk++;
      dclk_gap  = cyc - last_dclk;
      last_dclk = cyc;
    end
    if (underrun) n_ur++;
    if (d_out) n_ones++;
    if (d_in_ready && !prev_ready) n_rrise++;
    prev_ready = d_in_ready;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_dclk = cyc;
    clr_cnt();
  endtask

  task automatic wait_dclk(input string tag, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      seen = d_clk;
    end
    check(tag, int'(seen), 1, 1);
  endtask

  task automatic run_dc(input string tag, input int val, input int lo, input int hi);
    do_reset();
    interpolation_ratio = 16'd64;
    d_in = 16'(val);
    d_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) wait_dclk({tag, "_start"}, 200);
    clr_cnt();
    repeat (4096) tick();
    check({tag, "_ones"}, n_ones, lo, hi);
    check({tag, "_dclk_count"}, n_dclk, 64, 64);
    check({tag, "_dclk_gap"}, dclk_gap, 64, 64);
    check({tag, "_underrun"}, n_ur, 0, 0);
    check({tag, "_ready_rise"}, n_rrise, 64, 64);
    d_in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] idle_bits;
    logic signed [15:0] ur_samp [3];
    bit hit;

    rst = 1'b1;
    interpolation_ratio = 16'd8;
    d_in = '0;
    d_in_valid = 1'b0;
    #12;
    check("rst_d_out", int'(d_out), 0, 0);
    check("rst_d_clk", int'(d_clk), 0, 0);
    check("rst_underrun", int'(underrun), 0, 0);
    check("rst_overload", int'(overload), 0, 0);
    check("rst_ready", int'(d_in_ready), 1, 1);

    // Idle, x = 0: from zero state the loop emits 1,1,0,1 then repeats 0,0,1,1.
    do_reset();
    idle_bits = 8'b1100_1011;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("idle_bit%0d", i), int'(d_out), int'(idle_bits[i]), int'(idle_bits[i]));
    end
    clr_cnt();
    repeat (1024) tick();
    check("idle_ones", n_ones, 510, 514);
    check("idle_underrun_count", n_ur, 128, 128);
    check("idle_dclk", n_dclk, 0, 0);
    check("idle_overload", int'(overload), 0, 0);

    // DC at +FS/4 -> 0.625 density, and -FS/4 -> 0.375 density.
    run_dc("dc_pos", 8192, 2540, 2580);
    run_dc("dc_neg", -8192, 1516, 1556);

    // Ratio 64 -> 16 mid-frame with a sequence-numbered stream.
    do_reset();
    seq_mode = 1'b1;
    interpolation_ratio = 16'd64;
    d_in = '0;
    d_in_valid = 1'b1;
    wait_dclk("ratio_d1", 200);
    wait_dclk("ratio_d2", 200);
    repeat (10) tick();
    interpolation_ratio = 16'd16;
    wait_dclk("ratio_d3", 200);
    check("ratio_gap_old", dclk_gap, 64, 64);
    wait_dclk("ratio_d4", 200);
    check("ratio_gap_new1", dclk_gap, 16, 16);
    wait_dclk("ratio_d5", 200);
    check("ratio_gap_new2", dclk_gap, 16, 16);
    check("ratio_dclk_total", n_dclk, 5, 5);
    check("ratio_transfers", n_tx, 5, 5);
    check("ratio_seq_next", int'(d_in), 5, 5);
    d_in_valid = 1'b0;
    seq_mode = 1'b0;

    // Underrun: three samples, the last at FS/2 (density 0.75), then silence.
    do_reset();
    interpolation_ratio = 16'd16;
    ur_samp[0] = 16'sd0;
    ur_samp[1] = 16'sd4096;
    ur_samp[2] = 16'sd16384;
    d_in = ur_samp[0];
    d_in_valid = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      tick();
      if (n_tx < 3) d_in = ur_samp[n_tx];
      else d_in_valid = 1'b0;
      hit = (n_dclk == 3);
    end
    check("ur_three_dclk", n_dclk, 3, 3);
    clr_cnt();
    repeat (160) tick();
    check("ur_pulses", n_ur, 10, 10);
    check("ur_no_dclk", n_dclk, 0, 0);
    clr_cnt();
    repeat (1024) tick();
    check("ur_hold_ones", n_ones, 760, 776);

    // Overload with +FS-1, then async reset mid-frame.
    do_reset();
    interpolation_ratio = 16'd16;
    d_in = 16'sd32767;
    d_in_valid = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      tick();
      hit = overload;
    end
    check("ovl_set", int'(overload), 1, 1);
    repeat (50) tick();
    check("ovl_sticky", int'(overload), 1, 1);
    wait_dclk("ovl_frame", 100);
    repeat (3) tick();
    #2;
    check("ovl_buf_full_before_rst", int'(d_in_ready), 0, 0);
    rst = 1'b1;
    #1;
    check("arst_d_out", int'(d_out), 0, 0);
    check("arst_d_clk", int'(d_clk), 0, 0);
    check("arst_underrun", int'(underrun), 0, 0);
    check("arst_overload", int'(overload), 0, 0);
    check("arst_ready", int'(d_in_ready), 1, 1);
    d_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_dclk = cyc;
    clr_cnt();
    tick();
    tick();
    check("arst_first_wrap_underrun", int'(underrun), 1, 1);
    check("arst_first_wrap_no_dclk", int'(d_clk), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
